capture_controller: RTL

- Acquisition sequencer for the logic analyzer. Samples the enabled input channels at a programmable rate into a circular sample buffer.
- Handles pre-trigger fill, trigger detection and post-trigger fill, then freezes the buffer.
- Once frozen, the buffer is exposed through a column-addressed read port. The VGA pixel path indexes that port with the next display column, so column 0 is the oldest retained sample.

---
 rtl/capture_controller_pkg.sv | 33 +++
 rtl/capture_controller_sample_ram.sv | 33 +++
 rtl/capture_controller.sv | 196 +++++++++++++++++++
 3 files changed

// File: rtl/capture_controller_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : capture_controller_pkg
//  Purpose  : Shared constants and state encoding for the capture sequencer.
//  Revision : 1.0  initial release
// ============================================================================
package capture_controller_pkg;

    localparam int c_chan_count = 10;
    // One sample per visible VGA column.
    localparam int c_vga_cols   = 640;
    localparam int c_depth      = c_vga_cols;

    localparam logic [2:0] c_st_idle = 3'd0;
    localparam logic [2:0] c_st_pre  = 3'd1;
    localparam logic [2:0] c_st_wait = 3'd2;
    localparam logic [2:0] c_st_post = 3'd3;
    localparam logic [2:0] c_st_done = 3'd4;

    typedef enum logic [2:0] {
        ST_IDLE = c_st_idle,
        ST_PRE  = c_st_pre,
        ST_WAIT = c_st_wait,
        ST_POST = c_st_post,
        ST_DONE = c_st_done
    } state_t;

    function automatic int addr_bits(input int depth);
        return (depth > 1) ? $clog2(depth) : 1;
    endfunction

endpackage
`default_nettype wire

// File: rtl/capture_controller_sample_ram.sv
`default_nettype none
// ============================================================================
//  Module   : sample_ram
//  Purpose  : DEPTH x WIDTH sample store, one write port, registered read port.
//  Revision : 1.0  initial release
// ============================================================================
module sample_ram #(
    parameter int DEPTH  = 640,
    parameter int ADDR_W = 10,
    parameter int WIDTH  = 10
) (
    input  logic              clk,
    input  logic              i_wr_en,
    input  logic [ADDR_W-1:0] i_wr_addr,
    input  logic [WIDTH-1:0]  i_wr_data,
    input  logic [ADDR_W-1:0] i_rd_addr,
    output logic [WIDTH-1:0]  o_rd_data
);

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [WIDTH-1:0] r_rd_data;

    always_ff @(posedge clk) begin
        if (i_wr_en) begin
            r_mem[i_wr_addr] <= i_wr_data;
        end
        r_rd_data <= r_mem[i_rd_addr];
    end

    assign o_rd_data = r_rd_data;

endmodule
`default_nettype wire

// File: rtl/capture_controller.sv
`default_nettype none
// ============================================================================
//  Module   : capture_controller
//  Purpose  : Pre/post-trigger acquisition into a circular buffer, frozen and
//             read back by display column. LA_TRIG_EDGE_EN adds edge triggers.
//  Revision : 1.0  initial release
// ============================================================================
module capture_controller
    import capture_controller_pkg::*;
#(
    parameter int CHAN_COUNT = c_chan_count,
    parameter int DEPTH      = c_depth,
    parameter int ADDR_W     = 10,
    parameter int PRE_TRIG   = 160
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [CHAN_COUNT-1:0] chan_in,
    input  logic [CHAN_COUNT-1:0] chan_enable,
    input  logic                  arm,
    input  logic [15:0]           sample_div,
    input  logic [CHAN_COUNT-1:0] trig_mask,
    input  logic [CHAN_COUNT-1:0] trig_value,
`ifdef LA_TRIG_EDGE_EN
    input  logic [CHAN_COUNT-1:0] trig_edge,
`endif
    input  logic [ADDR_W-1:0]     rd_col,
    output logic [CHAN_COUNT-1:0] rd_data,
    output logic                  busy,
    output logic                  triggered,
    output logic                  done
);

    localparam int c_aw = addr_bits(DEPTH);

    localparam logic [c_aw-1:0]   c_one       = c_aw'(1);
    localparam logic [c_aw-1:0]   c_last_ptr  = c_aw'(DEPTH - 1);
    localparam logic [c_aw-1:0]   c_pre_trig  = c_aw'(PRE_TRIG);
    localparam logic [c_aw-1:0]   c_post_len  = c_aw'(DEPTH - PRE_TRIG - 1);
    localparam logic [c_aw-1:0]   c_wrap_adj  = c_aw'(DEPTH - PRE_TRIG);
    localparam logic [ADDR_W:0]   c_depth_ext = (ADDR_W + 1)'(DEPTH);

    state_t                r_state;
    state_t                w_state_next;
    logic [15:0]           r_div_cnt;
    logic [c_aw-1:0]       r_wr_ptr;
    logic [c_aw-1:0]       r_pre_cnt;
    logic [c_aw-1:0]       r_post_cnt;
    logic [c_aw-1:0]       r_start_ptr;
    logic                  r_triggered;
    logic                  r_rd_valid;

    logic                  w_strobe;
    logic                  w_start;
    logic                  w_fire;
    logic                  w_wr_en;
    logic                  w_trig_hit;
    logic [CHAN_COUNT-1:0] w_sample;
    logic [CHAN_COUNT-1:0] w_bit_ok;
    logic [c_aw-1:0]       w_start_calc;
    logic [ADDR_W:0]       w_rd_sum;
    logic [c_aw-1:0]       w_rd_addr;
    logic [CHAN_COUNT-1:0] w_ram_q;

    // >= rather than == so a smaller sample_div written mid-count never stalls.
    assign w_strobe = (r_div_cnt >= sample_div);
    assign w_sample = chan_in & chan_enable;

`ifdef LA_TRIG_EDGE_EN
    logic [CHAN_COUNT-1:0] r_prev_sample;

    always_ff @(posedge clk) begin
        if (reset || w_start) begin
            r_prev_sample <= '0;
        end else if (w_strobe) begin
            r_prev_sample <= w_sample;
        end
    end

    // Edge channels also require the previous sample to differ from the target.
    assign w_bit_ok = ~(w_sample ^ trig_value)
                    & (~trig_edge | (r_prev_sample ^ trig_value));
`else
    assign w_bit_ok = ~(w_sample ^ trig_value);
`endif

    assign w_trig_hit   = &(w_bit_ok | ~trig_mask);
    assign w_start_calc = (r_wr_ptr >= c_pre_trig) ? (r_wr_ptr - c_pre_trig)
                                                   : (r_wr_ptr + c_wrap_adj);

    always_comb begin
        w_state_next = r_state;
        w_start      = 1'b0;
        w_fire       = 1'b0;
        w_wr_en      = 1'b0;
        case (r_state)
            ST_IDLE, ST_DONE: begin
                if (arm) begin
                    w_start      = 1'b1;
                    w_state_next = (c_pre_trig == '0) ? ST_WAIT : ST_PRE;
                end
            end
            ST_PRE: begin
                if (w_strobe) begin
                    w_wr_en = 1'b1;
                    if ((r_pre_cnt + c_one) == c_pre_trig) begin
                        w_state_next = ST_WAIT;
                    end
                end
            end
            ST_WAIT: begin
                if (w_strobe) begin
                    w_wr_en = 1'b1;
                    if (w_trig_hit) begin
                        w_fire       = 1'b1;
                        w_state_next = ST_POST;
                    end
                end
            end
            ST_POST: begin
                if (r_post_cnt == '0) begin
                    w_state_next = ST_DONE;
                end else if (w_strobe) begin
                    w_wr_en = 1'b1;
                end
            end
            default: w_state_next = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state     <= ST_IDLE;
            r_div_cnt   <= '0;
            r_wr_ptr    <= '0;
            r_pre_cnt   <= '0;
            r_post_cnt  <= '0;
            r_start_ptr <= '0;
            r_triggered <= 1'b0;
            r_rd_valid  <= 1'b0;
        end else begin
            r_state    <= w_state_next;
            r_rd_valid <= (r_state == ST_DONE) && ((ADDR_W + 1)'(rd_col) < c_depth_ext);

            if (w_start || w_strobe) begin
                r_div_cnt <= '0;
            end else begin
                r_div_cnt <= r_div_cnt + 16'd1;
            end

            if (w_start) begin
                r_wr_ptr    <= '0;
                r_pre_cnt   <= '0;
                r_triggered <= 1'b0;
            end else if (w_wr_en) begin
                r_wr_ptr <= (r_wr_ptr == c_last_ptr) ? '0 : (r_wr_ptr + c_one);
                if (r_state == ST_PRE) begin
                    r_pre_cnt <= r_pre_cnt + c_one;
                end
            end

            if (w_fire) begin
                r_start_ptr <= w_start_calc;
                r_post_cnt  <= c_post_len;
                r_triggered <= 1'b1;
            end else if (w_wr_en && (r_state == ST_POST)) begin
                r_post_cnt <= r_post_cnt - c_one;
            end
        end
    end

    // Column 0 maps to the oldest retained sample.
    assign w_rd_sum  = (ADDR_W + 1)'(rd_col) + (ADDR_W + 1)'(r_start_ptr);
    assign w_rd_addr = (w_rd_sum >= c_depth_ext) ? c_aw'(w_rd_sum - c_depth_ext)
                                                 : c_aw'(w_rd_sum);

    sample_ram #(
        .DEPTH  (DEPTH),
        .ADDR_W (c_aw),
        .WIDTH  (CHAN_COUNT)
    ) u_sample_ram (
        .clk       (clk),
        .i_wr_en   (w_wr_en),
        .i_wr_addr (r_wr_ptr),
        .i_wr_data (w_sample),
        .i_rd_addr (w_rd_addr),
        .o_rd_data (w_ram_q)
    );

    assign rd_data   = r_rd_valid ? w_ram_q : '0;
    assign busy      = (r_state == ST_PRE) || (r_state == ST_WAIT) || (r_state == ST_POST);
    assign triggered = r_triggered;
    assign done      = (r_state == ST_DONE);

endmodule
`default_nettype wire
